adc_async_fill_mux: RTL and testbench
=====================================

Name: adc_async_fill_mux

Overview:
Builds every 132-bit word (4-bit tag + 128-bit payload) that the ASYNC acquisition path writes to the DDR3 input FIFO: fill header, waveform header, packed ADC data, or checksum.
It also holds the 24-bit fill-number counter and the 23-bit DDR3 burst-address counter that feed those headers.
It sits between the circular-buffer read registers / sequencing state machine and the DDR3 write FIFO, all in the adc_clk domain.

Parameters:
none (widths fixed; tag codes and field offsets live in the shared package)

Ports:
adc_clk  in  1  ADC clock; all state on rising edge
reset_clk_adc  in  1  asynchronous, active-low reset
dat3_,dat2_,dat1_,dat0_  in  26 each  {ovrB,ovrA,sampleB[11:0],sampleA[11:0]}; dat0_ oldest
channel_tag  in  12  channel information for headers
fill_type  in  2  acquisition enable levels
num_fill_bursts  in  23  total bursts in fill
waveform_start_adr  in  23  DDR3 burst address of current waveform
current_waveform_num  in  23  waveform number
async_num_bursts  in  11  8-sample bursts per waveform
async_pre_trig  in  12  pre-trigger clock count
xadc_alarms  in  4  XADC alarm bits
select_dat, select_fill_hdr, select_waveform_hdr, select_checksum  in  1 each  output source selects
checksum_init, checksum_update  in  1 each  checksum control
initial_fill_num  in  24  fill-counter load value
fill_init, fill_en  in  1 each  load / increment fill counter
burst_adr_init, burst_adr_en  in  1 each  preset-to-1 / increment burst address
adc_acq_out_dat  out  132  [131:128] tag, [127:0] payload
fill_num  out  24  current fill number
burst_adr  out  23  current DDR3 burst address

Behaviour:
- Reset values: adc_acq_out_dat 0; checksum accumulator 0; fill_num 0; burst_adr 1.
- adc_acq_out_dat is registered with 1-cycle latency: a select asserted at edge N appears after edge N. Inputs are sampled at that same edge.
- Select priority: checksum > fill_hdr > waveform_hdr > dat. With no select asserted, the output holds its previous value.
- Tags: data 4'h0, fill header 4'h1, waveform header 4'h2, checksum 4'h3.
- Data payload: eight 16-bit lanes, lane k at [16k+15:16k], each lane = {ovr,3'b000,sample[11:0]}.
  - Lane order: dat0_.A, dat0_.B, dat1_.A, dat1_.B, dat2_.A, dat2_.B, dat3_.A, dat3_.B.
  - ovrA = bit24, ovrB = bit25, sampleA = [11:0], sampleB = [23:12].
- Fill header payload: [23:0] fill_num, [46:24] num_fill_bursts, [58:47] channel_tag, [60:59] fill_type, [64:61] xadc_alarms, [127:65] 0.
- Waveform header payload: [22:0] current_waveform_num, [45:23] waveform_start_adr, [56:46] async_num_bursts, [68:57] async_pre_trig, [80:69] channel_tag, [127:81] 0.
- Checksum: 128-bit accumulator.
  - checksum_init clears it to 0.
  - Otherwise, checksum_update XORs in the current adc_acq_out_dat[127:0].
  - init has priority over update in the same cycle.
  - Checksum word payload = the accumulator value at the selecting edge.
- Fill counter: fill_init loads initial_fill_num; else fill_en increments by 1, wrapping 0xFFFFFF -> 0. init has priority. fill_num updates 1 cycle after the strobe.
- Burst-address counter: burst_adr_init sets it to 1; else burst_adr_en increments, wrapping 0x7FFFFF -> 0. init has priority.
- Reset asserted mid-operation clears all state immediately (asynchronous); outputs take their reset values.

Decomposition:
- Package adc_async_pkg: tag constants; header field LSB/MSB constants; lane width 16.
- One natural sub-module: async_up_counter (width, preset value, load, enable, wrap). Instantiated twice: fill counter (24-bit, load input) and burst address (23-bit, preset 1).

Test Plan:
- Reset, then release -> adc_acq_out_dat=0, fill_num=0, burst_adr=1.
- dat0_=26'h1_001_002 (ovrA=1, B=0x001, A=0x002), others 0; select_dat -> tag 0, lanes [15:0]=16'h8002, [31:16]=16'h0001, rest 0.
- initial_fill_num=24'hFFFFFE, fill_init, then 3x fill_en -> fill_num sequence FFFFFE, FFFFFF, 000000, 000001. fill_init and fill_en same cycle -> load wins.
- burst_adr_en x5 after init -> 6. burst_adr_init with burst_adr_en together -> 1.
- Fill header with fill_num=0x123456, num_fill_bursts=0x10, channel_tag=0xABC, fill_type=2, xadc_alarms=0x5 -> tag 1, payload fields at the specified offsets, upper bits 0.
- checksum_init; two data words P1, P2 each with checksum_update; then select_checksum -> tag 3, payload P1^P2. All four selects together -> checksum wins.

Source files
------------

// File: rtl/adc_async_pkg.sv
// Shared constants for the ASYNC acquisition word builder: tag codes, header field
// offsets and the ADC data lane packing helper.
package adc_async_pkg;

    localparam int unsigned TagW      = 4;
    localparam int unsigned PayloadW  = 128;
    localparam int unsigned WordW     = TagW + PayloadW;
    localparam int unsigned LaneW     = 16;
    localparam int unsigned FillNumW  = 24;
    localparam int unsigned BurstAdrW = 23;

    localparam logic [TagW-1:0] TagDat     = 4'h0;
    localparam logic [TagW-1:0] TagFillHdr = 4'h1;
    localparam logic [TagW-1:0] TagWfHdr   = 4'h2;
    localparam logic [TagW-1:0] TagChksum  = 4'h3;

    // Fill header field LSBs
    localparam int unsigned FhFillNumLsb  = 0;
    localparam int unsigned FhFillNumMsb  = 23;
    localparam int unsigned FhNumBurstLsb = 24;
    localparam int unsigned FhNumBurstMsb = 46;
    localparam int unsigned FhChanLsb     = 47;
    localparam int unsigned FhChanMsb     = 58;
    localparam int unsigned FhTypeLsb     = 59;
    localparam int unsigned FhTypeMsb     = 60;
    localparam int unsigned FhAlarmLsb    = 61;
    localparam int unsigned FhAlarmMsb    = 64;

    // Waveform header field LSBs
    localparam int unsigned WhWfNumLsb    = 0;
    localparam int unsigned WhWfNumMsb    = 22;
    localparam int unsigned WhStartAdrLsb = 23;
    localparam int unsigned WhStartAdrMsb = 45;
    localparam int unsigned WhNumBurstLsb = 46;
    localparam int unsigned WhNumBurstMsb = 56;
    localparam int unsigned WhPreTrigLsb  = 57;
    localparam int unsigned WhPreTrigMsb  = 68;
    localparam int unsigned WhChanLsb     = 69;
    localparam int unsigned WhChanMsb     = 80;

    // One 26-bit sample pair {ovrB,ovrA,sampleB,sampleA} -> {laneB, laneA}
    function automatic logic [2*LaneW-1:0] pack_pair(input logic [25:0] d);
        logic [LaneW-1:0] lane_a;
        logic [LaneW-1:0] lane_b;
        lane_a = {d[24], 3'b000, d[11:0]};
        lane_b = {d[25], 3'b000, d[23:12]};
        return {lane_b, lane_a};
    endfunction

endpackage

// File: rtl/adc_async_fill_mux_if.sv
// Bus bundle between the ASYNC sequencer / circular-buffer readout and the word builder.
interface adc_async_fill_mux_if;

    logic [25:0]  dat3_;
    logic [25:0]  dat2_;
    logic [25:0]  dat1_;
    logic [25:0]  dat0_;
    logic [11:0]  channel_tag;
    logic [1:0]   fill_type;
    logic [22:0]  num_fill_bursts;
    logic [22:0]  waveform_start_adr;
    logic [22:0]  current_waveform_num;
    logic [10:0]  async_num_bursts;
    logic [11:0]  async_pre_trig;
    logic [3:0]   xadc_alarms;
    logic         select_dat;
    logic         select_fill_hdr;
    logic         select_waveform_hdr;
    logic         select_checksum;
    logic         checksum_init;
    logic         checksum_update;
    logic [23:0]  initial_fill_num;
    logic         fill_init;
    logic         fill_en;
    logic         burst_adr_init;
    logic         burst_adr_en;
    logic [131:0] adc_acq_out_dat;
    logic [23:0]  fill_num;
    logic [22:0]  burst_adr;

    modport master (
        output dat3_, dat2_, dat1_, dat0_, channel_tag, fill_type, num_fill_bursts,
               waveform_start_adr, current_waveform_num, async_num_bursts, async_pre_trig,
               xadc_alarms, select_dat, select_fill_hdr, select_waveform_hdr, select_checksum,
               checksum_init, checksum_update, initial_fill_num, fill_init, fill_en,
               burst_adr_init, burst_adr_en,
        input  adc_acq_out_dat, fill_num, burst_adr
    );

    modport slave (
        input  dat3_, dat2_, dat1_, dat0_, channel_tag, fill_type, num_fill_bursts,
               waveform_start_adr, current_waveform_num, async_num_bursts, async_pre_trig,
               xadc_alarms, select_dat, select_fill_hdr, select_waveform_hdr, select_checksum,
               checksum_init, checksum_update, initial_fill_num, fill_init, fill_en,
               burst_adr_init, burst_adr_en,
        output adc_acq_out_dat, fill_num, burst_adr
    );

endinterface

// File: rtl/async_up_counter.sv
// Loadable wrap-around up counter; load has priority over enable.
module async_up_counter #(
    parameter int unsigned       Width    = 24,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d;
    logic [Width-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_async_fill_mux.sv
// Builds the 132-bit tagged words (data, fill header, waveform header, checksum) written
// to the DDR3 input FIFO, and owns the fill-number and burst-address counters.
module adc_async_fill_mux
    import adc_async_pkg::*;
(
    input logic                 adc_clk,
    input logic                 reset_clk_adc,
    adc_async_fill_mux_if.slave bus
);

    logic [WordW-1:0]     out_d;
    logic [WordW-1:0]     out_q;
    logic [PayloadW-1:0]  csum_d;
    logic [PayloadW-1:0]  csum_q;
    logic [PayloadW-1:0]  dat_payload;
    logic [PayloadW-1:0]  fill_hdr;
    logic [PayloadW-1:0]  wf_hdr;
    logic [FillNumW-1:0]  fill_num;
    logic [BurstAdrW-1:0] burst_adr;

    async_up_counter #(
        .Width    (FillNumW),
        .ResetVal ('0)
    ) u_fill_cnt (
        .clk_i      (adc_clk),
        .rst_ni     (reset_clk_adc),
        .load_i     (bus.fill_init),
        .load_val_i (bus.initial_fill_num),
        .en_i       (bus.fill_en),
        .cnt_o      (fill_num)
    );

    async_up_counter #(
        .Width    (BurstAdrW),
        .ResetVal (BurstAdrW'(1))
    ) u_burst_cnt (
        .clk_i      (adc_clk),
        .rst_ni     (reset_clk_adc),
        .load_i     (bus.burst_adr_init),
        .load_val_i (BurstAdrW'(1)),
        .en_i       (bus.burst_adr_en),
        .cnt_o      (burst_adr)
    );

    always_comb begin
        dat_payload = {pack_pair(bus.dat3_), pack_pair(bus.dat2_),
                       pack_pair(bus.dat1_), pack_pair(bus.dat0_)};

        fill_hdr = '0;
        fill_hdr[FhFillNumMsb:FhFillNumLsb]   = fill_num;
        fill_hdr[FhNumBurstMsb:FhNumBurstLsb] = bus.num_fill_bursts;
        fill_hdr[FhChanMsb:FhChanLsb]         = bus.channel_tag;
        fill_hdr[FhTypeMsb:FhTypeLsb]         = bus.fill_type;
        fill_hdr[FhAlarmMsb:FhAlarmLsb]       = bus.xadc_alarms;

        wf_hdr = '0;
        wf_hdr[WhWfNumMsb:WhWfNumLsb]         = bus.current_waveform_num;
        wf_hdr[WhStartAdrMsb:WhStartAdrLsb]   = bus.waveform_start_adr;
        wf_hdr[WhNumBurstMsb:WhNumBurstLsb]   = bus.async_num_bursts;
        wf_hdr[WhPreTrigMsb:WhPreTrigLsb]     = bus.async_pre_trig;
        wf_hdr[WhChanMsb:WhChanLsb]           = bus.channel_tag;
    end

    // No select asserted: the output word is held.
    always_comb begin
        out_d = out_q;
        if (bus.select_checksum) begin
            out_d = {TagChksum, csum_q};
        end else if (bus.select_fill_hdr) begin
            out_d = {TagFillHdr, fill_hdr};
        end else if (bus.select_waveform_hdr) begin
            out_d = {TagWfHdr, wf_hdr};
        end else if (bus.select_dat) begin
            out_d = {TagDat, dat_payload};
        end
    end

    // Accumulates the word currently on the output, not the one being selected.
    always_comb begin
        csum_d = csum_q;
        if (bus.checksum_init) begin
            csum_d = '0;
        end else if (bus.checksum_update) begin
            csum_d = csum_q ^ out_q[PayloadW-1:0];
        end
    end

    always_ff @(posedge adc_clk or negedge reset_clk_adc) begin
        if (!reset_clk_adc) begin
            out_q  <= '0;
            csum_q <= '0;
        end else begin
            out_q  <= out_d;
            csum_q <= csum_d;
        end
    end

    assign bus.adc_acq_out_dat = out_q;
    assign bus.fill_num        = fill_num;
    assign bus.burst_adr       = burst_adr;

endmodule

// File: tb/tb_adc_async_fill_mux.sv
// Directed self-checking bench for adc_async_fill_mux with hand-computed expected words.
module tb_adc_async_fill_mux;

    logic adc_clk = 1'b0;
    logic reset_clk_adc = 1'b0;
    int   checks = 0;
    int   failures = 0;

    adc_async_fill_mux_if bus ();

    adc_async_fill_mux dut (
        .adc_clk       (adc_clk),
        .reset_clk_adc (reset_clk_adc),
        .bus           (bus)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    localparam logic [127:0] P1      = 128'h8FFF0000_00000000_00000000_00018002;
    localparam logic [127:0] P2      = 128'h00000000_80008000_0ABC0123_00000000;
    localparam logic [127:0] P1XP2   = 128'h8FFF0000_80008000_0ABC0123_00018002;
    localparam logic [127:0] FHDR    = 128'h00000000_00000000_B55E0000_10123456;
    localparam logic [127:0] WHDR    = 128'h00000000_00015780_03FFC000_00FFFFFF;

    initial begin
        bus.dat3_ = '0; bus.dat2_ = '0; bus.dat1_ = '0; bus.dat0_ = '0;
        bus.channel_tag = '0; bus.fill_type = '0; bus.num_fill_bursts = '0;
        bus.waveform_start_adr = '0; bus.current_waveform_num = '0;
        bus.async_num_bursts = '0; bus.async_pre_trig = '0; bus.xadc_alarms = '0;
        bus.select_dat = 1'b0; bus.select_fill_hdr = 1'b0;
        bus.select_waveform_hdr = 1'b0; bus.select_checksum = 1'b0;
        bus.checksum_init = 1'b0; bus.checksum_update = 1'b0;
        bus.initial_fill_num = '0; bus.fill_init = 1'b0; bus.fill_en = 1'b0;
        bus.burst_adr_init = 1'b0; bus.burst_adr_en = 1'b0;

        // Reset
        step(); step();
        check("rst_out", bus.adc_acq_out_dat, 132'h0);
        check("rst_fill", 132'(bus.fill_num), 132'h0);
        check("rst_burst", 132'(bus.burst_adr), 132'h1);
        reset_clk_adc = 1'b1;
        step();
        check("post_rst_out", bus.adc_acq_out_dat, 132'h0);
        check("post_rst_burst", 132'(bus.burst_adr), 132'h1);

        // Data word lane packing
        bus.dat0_ = 26'h1001002;
        bus.select_dat = 1'b1;
        step();
        bus.select_dat = 1'b0;
        check("dat_lanes", bus.adc_acq_out_dat, {4'h0, 128'h00018002});
        bus.dat0_ = 26'h0;
        step();
        check("dat_hold", bus.adc_acq_out_dat, {4'h0, 128'h00018002});

        // Fill counter load and wrap
        bus.initial_fill_num = 24'hFFFFFE;
        bus.fill_init = 1'b1;
        step();
        bus.fill_init = 1'b0;
        check("fill_load", 132'(bus.fill_num), 132'hFFFFFE);
        bus.fill_en = 1'b1;
        step();
        check("fill_inc1", 132'(bus.fill_num), 132'hFFFFFF);
        step();
        check("fill_wrap", 132'(bus.fill_num), 132'h000000);
        step();
        check("fill_inc3", 132'(bus.fill_num), 132'h000001);
        bus.initial_fill_num = 24'h123456;
        bus.fill_init = 1'b1;
        step();
        bus.fill_init = 1'b0;
        bus.fill_en = 1'b0;
        check("fill_load_prio", 132'(bus.fill_num), 132'h123456);

        // Burst address counter
        bus.burst_adr_en = 1'b1;
        step();
        check("burst_en_noinit", 132'(bus.burst_adr), 132'h2);
        bus.burst_adr_en = 1'b0;
        bus.burst_adr_init = 1'b1;
        step();
        bus.burst_adr_init = 1'b0;
        check("burst_init", 132'(bus.burst_adr), 132'h1);
        bus.burst_adr_en = 1'b1;
        repeat (5) step();
        check("burst_x5", 132'(bus.burst_adr), 132'h6);
        bus.burst_adr_init = 1'b1;
        step();
        bus.burst_adr_init = 1'b0;
        bus.burst_adr_en = 1'b0;
        check("burst_init_prio", 132'(bus.burst_adr), 132'h1);

        // Fill header
        bus.num_fill_bursts = 23'h10;
        bus.channel_tag = 12'hABC;
        bus.fill_type = 2'd2;
        bus.xadc_alarms = 4'h5;
        bus.select_fill_hdr = 1'b1;
        step();
        bus.select_fill_hdr = 1'b0;
        check("fill_hdr", bus.adc_acq_out_dat, {4'h1, FHDR});

        // Waveform header
        bus.current_waveform_num = 23'h7FFFFF;
        bus.waveform_start_adr = 23'h000001;
        bus.async_num_bursts = 11'h7FF;
        bus.async_pre_trig = 12'h001;
        bus.select_waveform_hdr = 1'b1;
        step();
        check("wf_hdr", bus.adc_acq_out_dat, {4'h2, WHDR});

        // fill_hdr beats waveform_hdr and dat
        bus.select_fill_hdr = 1'b1;
        bus.select_dat = 1'b1;
        step();
        bus.select_fill_hdr = 1'b0;
        bus.select_waveform_hdr = 1'b0;
        bus.select_dat = 1'b0;
        check("prio_fill_over_wf", bus.adc_acq_out_dat, {4'h1, FHDR});

        // Checksum over two data words
        bus.checksum_init = 1'b1;
        step();
        bus.checksum_init = 1'b0;
        bus.dat0_ = 26'h1001002; bus.dat1_ = 26'h0; bus.dat2_ = 26'h0; bus.dat3_ = 26'h2FFF000;
        bus.select_dat = 1'b1;
        step();
        check("csum_p1", bus.adc_acq_out_dat, {4'h0, P1});
        bus.dat0_ = 26'h0; bus.dat1_ = 26'h0ABC123; bus.dat2_ = 26'h3000000; bus.dat3_ = 26'h0;
        bus.checksum_update = 1'b1;
        step();
        check("csum_p2", bus.adc_acq_out_dat, {4'h0, P2});
        bus.select_dat = 1'b0;
        step();
        bus.checksum_update = 1'b0;
        bus.select_checksum = 1'b1;
        step();
        bus.select_checksum = 1'b0;
        check("csum_word", bus.adc_acq_out_dat, {4'h3, P1XP2});
        bus.select_dat = 1'b1;
        step();
        check("csum_dat_again", bus.adc_acq_out_dat, {4'h0, P2});
        bus.select_fill_hdr = 1'b1;
        bus.select_waveform_hdr = 1'b1;
        bus.select_checksum = 1'b1;
        step();
        bus.select_dat = 1'b0;
        bus.select_fill_hdr = 1'b0;
        bus.select_waveform_hdr = 1'b0;
        bus.select_checksum = 1'b0;
        check("prio_all_csum", bus.adc_acq_out_dat, {4'h3, P1XP2});

        // init beats update
        bus.checksum_init = 1'b1;
        bus.checksum_update = 1'b1;
        step();
        bus.checksum_init = 1'b0;
        bus.checksum_update = 1'b0;
        bus.select_checksum = 1'b1;
        step();
        bus.select_checksum = 1'b0;
        check("csum_init_prio", bus.adc_acq_out_dat, {4'h3, 128'h0});

        // Asynchronous reset mid-operation
        bus.fill_en = 1'b1;
        bus.burst_adr_en = 1'b1;
        bus.select_fill_hdr = 1'b1;
        step();
        check("pre_arst_fill", 132'(bus.fill_num), 132'h123457);
        #2;
        reset_clk_adc = 1'b0;
        #1;
        check("arst_out", bus.adc_acq_out_dat, 132'h0);
        check("arst_fill", 132'(bus.fill_num), 132'h0);
        check("arst_burst", 132'(bus.burst_adr), 132'h1);
        bus.fill_en = 1'b0;
        bus.burst_adr_en = 1'b0;
        bus.select_fill_hdr = 1'b0;
        step();
        reset_clk_adc = 1'b1;
        step();
        check("post_arst_out", bus.adc_acq_out_dat, 132'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
